// File: rtl/dram_pack_pkg.sv
// Shared state type and width helpers for the DRAM stream packer.
// Latency: none (type and constant definitions only).
// Backpressure: none.
package dram_pack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } pack_state_e;

  // Holds up to OUT-1 carried bits plus one full beat.
  function automatic int acc_width(input int in_w, input int out_w);
    return out_w + in_w - 1;
  endfunction

  // Wide enough to count every bit the accumulator can hold.
  function automatic int cnt_width(input int in_w, input int out_w);
    return $clog2(out_w + in_w);
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int bank_width(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

// File: rtl/dram_pack_addr_gen.sv
// Round-robin bank pointer with one-hot decode and a wrapping per-bank address.
// Latency: pointer/address update on the edge where advance is high; outputs are the current slot.
// Backpressure: none; advance is taken unconditionally, clear has priority over advance.
module dram_pack_addr_gen
  import dram_pack_pkg::*;
#(
  parameter int  NUM_BANKS  = 4,
  parameter int  BANK_DEPTH = 64,
  localparam int ADDR_W     = addr_width(BANK_DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 dram_to_mem_rst_i,
  input  logic                 clear,
  input  logic                 advance,
  output logic [NUM_BANKS-1:0] bank_onehot,
  output logic [ADDR_W-1:0]    addr
);

  localparam int BANK_W = bank_width(NUM_BANKS);

  logic [BANK_W-1:0] bank_q;
  logic [ADDR_W-1:0] addr_q;
  logic              bank_wrap;
  logic              addr_wrap;

  assign bank_wrap = (bank_q == BANK_W'(NUM_BANKS - 1));
  assign addr_wrap = (addr_q == ADDR_W'(BANK_DEPTH - 1));

  // Step the bank each word; the address only moves once every bank has been written.
  always_ff @(posedge clk_i or posedge dram_to_mem_rst_i) begin
    if (dram_to_mem_rst_i) begin
      bank_q <= '0;
      addr_q <= '0;
    end else if (clear) begin
      bank_q <= '0;
      addr_q <= '0;
    end else if (advance) begin
      if (bank_wrap) begin
        bank_q <= '0;
        addr_q <= addr_wrap ? '0 : addr_q + ADDR_W'(1);
      end else begin
        bank_q <= bank_q + BANK_W'(1);
      end
    end
  end

  assign bank_onehot = NUM_BANKS'(1) << bank_q;
  assign addr        = addr_q;

endmodule

// File: rtl/dram_stream_packer.sv
// Packs DRAM beats MSB-first into memory words and writes them round-robin over NUM_BANKS banks.
// Latency: 1 cycle from accepted beat to registered data/strobe/address; done_o one cycle after the last strobe.
// Backpressure: data_ready_o high only in FILL; no memory backpressure. DRAM_PACK_LAST_FLUSH_EN enables last_i flush.
module dram_stream_packer
  import dram_pack_pkg::*;
#(
  parameter int  DATA_IN_BITWIDTH  = 8,
  parameter int  DATA_OUT_BITWIDTH = 163,
  parameter int  NUM_BANKS         = 4,
  parameter int  BANK_DEPTH        = 64,
  parameter int  FRAME_W           = 16,
  localparam int ADDR_W            = addr_width(BANK_DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         dram_to_mem_rst_i,
  input  logic                         start_i,
  input  logic [FRAME_W-1:0]           num_words_i,
  input  logic [DATA_IN_BITWIDTH-1:0]  data_in_i,
  input  logic                         data_valid_i,
  input  logic                         last_i,
  output logic                         data_ready_o,
  output logic [DATA_OUT_BITWIDTH-1:0] data_out_o,
  output logic [NUM_BANKS-1:0]         memory_write_enable_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic                         done_o
);

  localparam int IN_W  = DATA_IN_BITWIDTH;
  localparam int OUT_W = DATA_OUT_BITWIDTH;
  localparam int ACC_W = acc_width(IN_W, OUT_W);
  localparam int CNT_W = cnt_width(IN_W, OUT_W);

  // Frame state. The accumulator keeps its cnt_q valid bits right-aligned, upper bits zero.
  pack_state_e        state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] left_q, left_d;
  logic               done_q, done_d;

  // Registered memory-side outputs.
  logic [OUT_W-1:0]     word_q;
  logic [NUM_BANKS-1:0] we_q;
  logic [ADDR_W-1:0]    addr_q;

  // What the beat currently on data_in_i would produce if accepted.
  logic               pk_emit;
  logic [OUT_W-1:0]   pk_word;
  logic [ACC_W-1:0]   pk_acc;
  logic [CNT_W-1:0]   pk_cnt;

  logic               wr;
  logic [OUT_W-1:0]   wr_word;
  logic               ag_clear;
  logic [NUM_BANKS-1:0] bank_onehot;
  logic [ADDR_W-1:0]  bank_addr;

`ifdef DRAM_PACK_LAST_FLUSH_EN
  logic [OUT_W-1:0] pad_beat;
  logic [OUT_W-1:0] pad_held;

  // Left-align n residual bits in a word; the vacated LSBs are zero.
  function automatic logic [OUT_W-1:0] pad_residual(input logic [ACC_W-1:0] bits,
                                                    input logic [CNT_W-1:0] n);
    return OUT_W'(bits << (CNT_W'(OUT_W) - n));
  endfunction

  assign pad_beat = pad_residual(pk_acc, pk_cnt);
  assign pad_held = pad_residual(acc_q, cnt_q);
`else
  // last_i only matters when the flush feature is built in.
  logic unused_last;
  assign unused_last = last_i;
`endif

  generate
    if (IN_W < OUT_W) begin : g_pack
      logic [ACC_W-1:0] merged;
      logic [CNT_W-1:0] merged_cnt;
      logic [CNT_W-1:0] res_cnt;

      // Append the beat below the held bits; split off the top word once enough bits are present.
      always_comb begin
        merged     = (acc_q << IN_W) | ACC_W'(data_in_i);
        merged_cnt = cnt_q + CNT_W'(IN_W);
        pk_emit    = (merged_cnt >= CNT_W'(OUT_W));
        res_cnt    = pk_emit ? (merged_cnt - CNT_W'(OUT_W)) : merged_cnt;
        pk_word    = OUT_W'(merged >> res_cnt);
        pk_acc     = merged & ~({ACC_W{1'b1}} << res_cnt);
        pk_cnt     = res_cnt;
      end
    end else begin : g_trunc
      // A beat at least as wide as a word yields its top bits; the remainder is discarded.
      always_comb begin
        pk_emit = 1'b1;
        pk_word = data_in_i[IN_W-1 -: OUT_W];
        pk_acc  = '0;
        pk_cnt  = '0;
      end
    end
  endgenerate

  // Next state, frame bookkeeping and selection of the word to write this cycle.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    done_d   = done_q;
    wr       = 1'b0;
    wr_word  = pk_word;
    ag_clear = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) begin
          done_d = 1'b1;
        end
        if (start_i) begin
          left_d   = num_words_i;
          acc_d    = '0;
          cnt_d    = '0;
          ag_clear = 1'b1;
          if (num_words_i == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FILL;
            done_d  = 1'b0;
          end
        end
      end
      ST_FILL: begin
        if (data_valid_i) begin
          acc_d = pk_acc;
          cnt_d = pk_cnt;
          if (pk_emit) begin
            wr     = 1'b1;
            left_d = left_q - FRAME_W'(1);
            if (left_q == FRAME_W'(1)) begin
              // Word limit reached: any residual is dropped.
              state_d = ST_DONE;
              acc_d   = '0;
              cnt_d   = '0;
            end
`ifdef DRAM_PACK_LAST_FLUSH_EN
            else if (last_i) begin
              state_d = (pk_cnt != '0) ? ST_FLUSH : ST_DONE;
            end
`endif
          end
`ifdef DRAM_PACK_LAST_FLUSH_EN
          else if (last_i) begin
            // Residual-only end of frame: write it padded right away.
            wr      = 1'b1;
            wr_word = pad_beat;
            left_d  = left_q - FRAME_W'(1);
            state_d = ST_DONE;
            acc_d   = '0;
            cnt_d   = '0;
          end
`endif
        end
      end
      ST_FLUSH: begin
`ifdef DRAM_PACK_LAST_FLUSH_EN
        wr      = 1'b1;
        wr_word = pad_held;
        left_d  = left_q - FRAME_W'(1);
`endif
        state_d = ST_DONE;
        acc_d   = '0;
        cnt_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame state registers.
  always_ff @(posedge clk_i or posedge dram_to_mem_rst_i) begin
    if (dram_to_mem_rst_i) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      left_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      done_q  <= done_d;
    end
  end

  // Memory-side outputs: strobe pulses for one cycle, data and address hold between writes.
  always_ff @(posedge clk_i or posedge dram_to_mem_rst_i) begin
    if (dram_to_mem_rst_i) begin
      word_q <= '0;
      we_q   <= '0;
      addr_q <= '0;
    end else begin
      we_q <= wr ? bank_onehot : '0;
      if (wr) begin
        word_q <= wr_word;
        addr_q <= bank_addr;
      end
    end
  end

  dram_pack_addr_gen #(
    .NUM_BANKS  (NUM_BANKS),
    .BANK_DEPTH (BANK_DEPTH)
  ) u_addr_gen (
    .clk_i             (clk_i),
    .dram_to_mem_rst_i (dram_to_mem_rst_i),
    .clear             (ag_clear),
    .advance           (wr),
    .bank_onehot       (bank_onehot),
    .addr              (bank_addr)
  );

  assign data_ready_o          = (state_q == ST_FILL);
  assign data_out_o            = word_q;
  assign memory_write_enable_o = we_q;
  assign mem_addr_o            = addr_q;
  assign done_o                = done_q;

endmodule

// File: tb/tb_dram_stream_packer.sv
// Scoreboard bench: narrow-beat packer (8->20, 4 banks x 2) plus wide-beat truncating packer (16->12).
// Expected words come from a bit-queue model and a word-index bank/address model.
// Each accepted beat that completes a word pushes an expectation; write strobes pop and compare.
`timescale 1ns/1ps
module tb_dram_stream_packer;

  localparam int IA  = 8;
  localparam int OA  = 20;
  localparam int NB  = 4;
  localparam int DEP = 2;
  localparam int AWA = 1;
  localparam int FW  = 16;
  localparam int IB  = 16;
  localparam int OB  = 12;
  localparam int NBB = 2;
  localparam int AWB = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           start_a = 0, vld_a = 0, last_a = 0, rdy_a, done_a;
  logic [FW-1:0]  num_a = '0;
  logic [IA-1:0]  din_a = '0;
  logic [OA-1:0]  dout_a;
  logic [NB-1:0]  we_a;
  logic [AWA-1:0] addr_a;

  logic           start_b = 0, vld_b = 0, last_b = 0, rdy_b, done_b;
  logic [FW-1:0]  num_b = '0;
  logic [IB-1:0]  din_b = '0;
  logic [OB-1:0]  dout_b;
  logic [NBB-1:0] we_b;
  logic [AWB-1:0] addr_b;

  dram_stream_packer #(
    .DATA_IN_BITWIDTH(IA), .DATA_OUT_BITWIDTH(OA), .NUM_BANKS(NB), .BANK_DEPTH(DEP), .FRAME_W(FW)
  ) dut (
    .clk_i(clk), .dram_to_mem_rst_i(rst), .start_i(start_a), .num_words_i(num_a),
    .data_in_i(din_a), .data_valid_i(vld_a), .last_i(last_a), .data_ready_o(rdy_a),
    .data_out_o(dout_a), .memory_write_enable_o(we_a), .mem_addr_o(addr_a), .done_o(done_a)
  );

  dram_stream_packer #(
    .DATA_IN_BITWIDTH(IB), .DATA_OUT_BITWIDTH(OB), .NUM_BANKS(NBB), .BANK_DEPTH(4), .FRAME_W(FW)
  ) dut_wide (
    .clk_i(clk), .dram_to_mem_rst_i(rst), .start_i(start_b), .num_words_i(num_b),
    .data_in_i(din_b), .data_valid_i(vld_b), .last_i(last_b), .data_ready_o(rdy_b),
    .data_out_o(dout_b), .memory_write_enable_o(we_b), .mem_addr_o(addr_b), .done_o(done_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [OA-1:0]  word;
    logic [NB-1:0]  we;
    logic [AWA-1:0] addr;
    int             due;
  } exp_t;

  exp_t          sbq[$];
  bit            bitq[$];
  logic [IA-1:0] stim[$];
  int            last_due = 0;
  int            wr_b_cnt = 0;

  // Every strobe on the narrow packer must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (we_a != '0) begin
      if (sbq.size() == 0) begin
        chk_eq("unexpected_write", we_a, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk_eq("word", dout_a, e.word);
        chk_eq("bank_we", we_a, e.we);
        chk_eq("addr", addr_a, e.addr);
        chk_eq("latency_cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) if (we_b != '0) wr_b_cnt++;

  // Pull up to OA bits MSB-first from the model; missing bits read as zero padding.
  function automatic logic [OA-1:0] take_word();
    logic [OA-1:0] w;
    w = '0;
    for (int i = 0; i < OA; i++) begin
      w = w << 1;
      if (bitq.size() > 0) w[0] = bitq.pop_front();
    end
    return w;
  endfunction

  task automatic push_exp(input logic [OA-1:0] w, input int k, input int due);
    exp_t e;
    e.word = w;
    e.we = '0;
    e.we[k % NB] = 1'b1;
    e.addr = AWA'((k / NB) % DEP);
    e.due = due;
    sbq.push_back(e);
    last_due = due;
  endtask

  task automatic drive_beat(input logic [IA-1:0] b, input bit lst, output int acc_cyc, output bit ok);
    int gap;
    gap = $urandom_range(0, 1);
    repeat (gap) @(posedge clk);
    #1;
    din_a = b; vld_a = 1'b1; last_a = lst; ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk); ok = rdy_a;
      @(posedge clk); #1;
    end
    acc_cyc = cyc;
    vld_a = 1'b0; last_a = 1'b0;
    chk_eq("beat_accepted", ok, 1);
  endtask

  task automatic start_a_frame(input int nw);
    start_a = 1'b1; num_a = FW'(nw);
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; vld_a = 0; last_a = 0; start_a = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sbq.delete();
    @(posedge clk); #1;
  endtask

  // Drive stim[] as one frame of nw words; last_idx marks the beat carrying last_i (-1: none).
  task automatic run_frame(input int nw, input int last_idx, output bit over);
    int  k, e;
    bit  ok, emitted;
    k = 0; over = 1'b0;
    bitq.delete();
    start_a_frame(nw);
    for (int i = 0; i < stim.size() && !over; i++) begin
      drive_beat(stim[i], (i == last_idx), e, ok);
      if (!ok) return;
      for (int j = IA - 1; j >= 0; j--) bitq.push_back(stim[i][j]);
      emitted = 1'b0;
      if (bitq.size() >= OA) begin
        push_exp(take_word(), k, e);
        k++;
        emitted = 1'b1;
        if (k == nw) over = 1'b1;
      end
`ifdef DRAM_PACK_LAST_FLUSH_EN
      if (!over && i == last_idx) begin
        if (bitq.size() > 0) begin
          push_exp(take_word(), k, emitted ? e + 1 : e);
          k++;
          if (emitted) begin
            @(negedge clk);
            chk_eq("flush_ready_low", rdy_a, 0);
          end
        end
        over = 1'b1;
      end
`endif
    end
    if (over) begin
      @(negedge clk);
      while (cyc < last_due) @(negedge clk);
      chk_eq("done_low_at_last_write", done_a, 0);
      @(negedge clk);
      chk_eq("done_high", done_a, 1);
      chk_eq("ready_low_in_done", rdy_a, 0);
    end else begin
      repeat (3) @(negedge clk);
      chk_eq("no_done_midframe", done_a, 0);
      chk_eq("ready_midframe", rdy_a, 1);
    end
    chk_eq("scoreboard_drained", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit over;
    int nw, nbeats, li, e;
    bit ok;

    #1 rst = 1'b1;
    #2;
    chk_eq("rst_ready", rdy_a, 0);
    chk_eq("rst_we", we_a, 0);
    chk_eq("rst_data", dout_a, 0);
    chk_eq("rst_addr", addr_a, 0);
    chk_eq("rst_done", done_a, 0);
    chk_eq("rst_wide_ready", rdy_b, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Basic packing with a carried residual across the word boundary.
    stim = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    run_frame(2, -1, over);
    chk_eq("t1_hold_last_word", dout_a, 20'h6789A);

    // Nine words over four banks of depth two: address wraps back to 0.
    stim.delete();
    for (int i = 0; i < 23; i++) stim.push_back(IA'($urandom));
    run_frame(9, -1, over);

    // Residual-only end of frame.
    stim = '{8'hAB, 8'hCD};
    run_frame(5, 1, over);
`ifdef DRAM_PACK_LAST_FLUSH_EN
    chk_eq("t3_padded_word", dout_a, 20'hABCD0);
`endif
    if (!over) do_reset();

    // Full word plus residual on the last beat.
    stim = '{8'h12, 8'h34, 8'h56};
    run_frame(5, 2, over);
`ifdef DRAM_PACK_LAST_FLUSH_EN
    chk_eq("t4_flush_word", dout_a, 20'h60000);
`else
    chk_eq("t4_last_ignored", dout_a, 20'h12345);
`endif
    if (!over) do_reset();

    // Reset in the middle of a frame, then a clean frame must show no stale residual.
    start_a_frame(2);
    drive_beat(8'h12, 1'b0, e, ok);
    drive_beat(8'h34, 1'b0, e, ok);
    rst = 1'b1;
    #1;
    chk_eq("midrst_ready", rdy_a, 0);
    chk_eq("midrst_we", we_a, 0);
    chk_eq("midrst_data", dout_a, 0);
    chk_eq("midrst_addr", addr_a, 0);
    chk_eq("midrst_done", done_a, 0);
    do_reset();
    stim = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    run_frame(2, -1, over);

    // Word limit reached on the beat carrying last: residual dropped.
    stim = '{8'h12, 8'h34, 8'h56};
    run_frame(1, 2, over);
    chk_eq("t6_limit_word", dout_a, 20'h12345);

    // Random frames with random last placement.
    for (int f = 0; f < 4; f++) begin
      nw = $urandom_range(1, 5);
      nbeats = (nw * OA + IA - 1) / IA + $urandom_range(0, 1);
      li = $urandom_range(0, nbeats);
      if (li == nbeats) li = -1;
      stim.delete();
      for (int i = 0; i < nbeats; i++) stim.push_back(IA'($urandom));
      run_frame(nw, li, over);
      if (!over) do_reset();
    end

    // Wide beats: zero-word frame, then truncation to the top 12 bits.
    start_b = 1'b1; num_b = '0;
    @(posedge clk); #1 start_b = 1'b0;
    @(negedge clk);
    chk_eq("wide_zero_done", done_b, 1);
    chk_eq("wide_zero_ready", rdy_b, 0);
    repeat (2) @(negedge clk);
    chk_eq("wide_zero_no_write", wr_b_cnt, 0);
    @(posedge clk); #1;
    start_b = 1'b1; num_b = FW'(2);
    @(posedge clk); #1;
    start_b = 1'b0; vld_b = 1'b1; din_b = 16'hABCD;
    @(negedge clk);
    chk_eq("wide_ready", rdy_b, 1);
    @(posedge clk); #1 din_b = 16'h1234;
    @(negedge clk);
    chk_eq("wide_word0", dout_b, 12'hABC);
    chk_eq("wide_we0", we_b, 2'b01);
    chk_eq("wide_addr0", addr_b, 0);
    @(posedge clk); #1 vld_b = 1'b0;
    @(negedge clk);
    chk_eq("wide_word1", dout_b, 12'h123);
    chk_eq("wide_we1", we_b, 2'b10);
    chk_eq("wide_done_low", done_b, 0);
    @(negedge clk);
    chk_eq("wide_done_high", done_b, 1);
    chk_eq("wide_we_pulse", we_b, 0);
    chk_eq("wide_write_count", wr_b_cnt, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
